// File: rtl/psram_arbiter.sv
// Round-robin two-port arbiter and single-word transaction sequencer for the PSRAM quad interface.
// Handshake: a port's req is held until its one-cycle ack; the ack closes the transfer and carries read data.
module psram_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [22:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [22:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  input  logic        psram_ready,
  output logic        psram_quad_start,
  output logic [1:0]  psram_read_write,
  output logic [22:0] psram_address,
  output logic [15:0] psram_data_in,
  input  logic        psram_endcommand,
  input  logic [15:0] psram_data_out,
  output logic        busy,
  output logic        err,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_BUSY      = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;  // 0 = A, 1 = B
  logic             r_grant;
  logic             r_we;
  logic [22:0]      r_addr;
  logic [15:0]      r_wdata;
  logic [1:0]       r_rw;
  logic             r_a_ack;
  logic             r_b_ack;
  logic [15:0]      r_a_rdata;
  logic [15:0]      r_b_rdata;
  logic             r_err;
  logic             r_busy;

  logic             w_grant;
  logic             w_sel;
  logic             w_finish;
  logic             w_timeout;
  logic             w_we;
  logic [22:0]      w_addr;
  logic [15:0]      w_wdata;
  logic [15:0]      w_rd;

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_sel     = r_grant;
    w_finish  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_WAIT_INIT: if (psram_ready) w_next = S_IDLE;
      S_IDLE: begin
        if (a_req && b_req) begin
          w_grant = 1'b1;
          w_sel   = ~r_last_grant;
        end else if (a_req) begin
          w_grant = 1'b1;
          w_sel   = 1'b0;
        end else if (b_req) begin
          w_grant = 1'b1;
          w_sel   = 1'b1;
        end
        if (w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: w_next = S_BUSY;
      S_BUSY: begin
        // endcommand in the first BUSY cycle may be stale from the previous transfer
        if (psram_endcommand && (r_cnt != '0)) begin
          w_finish = 1'b1;
          w_next   = S_GAP;
        end else if (r_cnt == L_TO_LAST) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_GAP: if (r_cnt == L_GAP_LAST) w_next = S_IDLE;
      default: w_next = S_WAIT_INIT;
    endcase
    // Losing the PSRAM abandons everything in flight without an ack.
    if (!psram_ready && (r_state != S_WAIT_INIT)) begin
      w_next    = S_WAIT_INIT;
      w_grant   = 1'b0;
      w_finish  = 1'b0;
      w_timeout = 1'b0;
    end
  end

  assign w_we    = w_sel ? b_we : a_we;
  assign w_addr  = w_sel ? b_addr : a_addr;
  assign w_wdata = w_sel ? b_wdata : a_wdata;
  assign w_rd    = w_timeout ? 16'h0000 : psram_data_out;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if ((r_state == S_BUSY) || (r_state == S_GAP)) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rw         <= 2'd0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy  <= (w_next != S_IDLE);
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      if (w_grant) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_we         <= w_we;
        r_addr       <= w_addr;
        r_wdata      <= w_wdata;
        r_rw         <= w_we ? 2'd1 : 2'd2;
      end else if ((w_next == S_GAP) || (w_next == S_WAIT_INIT)) begin
        r_rw <= 2'd0;
      end
      if (w_finish) begin
        if (r_grant) r_b_ack <= 1'b1;
        else         r_a_ack <= 1'b1;
        if (!r_we) begin
          if (r_grant) r_b_rdata <= w_rd;
          else         r_a_rdata <= w_rd;
        end
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign psram_quad_start = (r_state == S_ISSUE);
  assign psram_read_write = r_rw;
  assign psram_address    = r_addr;
  assign psram_data_in    = r_wdata;
  assign a_ack            = r_a_ack;
  assign b_ack            = r_b_ack;
  assign a_rdata          = r_a_rdata;
  assign b_rdata          = r_b_rdata;
  assign busy             = r_busy;
  assign err              = r_err;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: a small PSRAM responder model plus one task per scenario.
module tb_psram_arbiter;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [22:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic        psram_ready;
  logic        psram_quad_start;
  logic [1:0]  psram_read_write;
  logic [22:0] psram_address;
  logic [15:0] psram_data_in;
  logic        psram_endcommand = 1'b0;
  logic [15:0] psram_data_out;
  logic        busy, err;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  int          model_delay = 0;  // 0 = never answer
  logic        model_stuck = 1'b0;
  logic [15:0] model_data  = 16'h0000;
  int          cd = 0;

  int cyc = 0;
  int n_qs = 0, n_a_ack = 0, n_b_ack = 0, n_both = 0;

  logic [0:0] exp_q[$];

  psram_arbiter dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .psram_ready(psram_ready), .psram_quad_start(psram_quad_start),
    .psram_read_write(psram_read_write), .psram_address(psram_address),
    .psram_data_in(psram_data_in), .psram_endcommand(psram_endcommand),
    .psram_data_out(psram_data_out), .busy(busy), .err(err),
    .o_dbg_state(dbg_state)
  );

  // clock / reset-independent infrastructure
  always #5 mem_clk = ~mem_clk;
  always @(posedge mem_clk) cyc++;

  assign psram_data_out = model_data;

  always @(negedge mem_clk) begin
    if (model_stuck) begin
      psram_endcommand = 1'b1;
      cd = 0;
    end else begin
      psram_endcommand = 1'b0;
      if (psram_quad_start) cd = model_delay;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) psram_endcommand = 1'b1;
      end
    end
  end

  always @(negedge mem_clk) begin
    if (psram_quad_start) n_qs++;
    if (a_ack) n_a_ack++;
    if (b_ack) n_b_ack++;
    if (a_ack && b_ack) n_both++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver helpers
  task automatic wait_qs(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge mem_clk);
      if (psram_quad_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int max_cyc, output bit sa, output bit sb, output int lat);
    sa = 1'b0; sb = 1'b0; lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge mem_clk);
      if (a_ack || b_ack) begin
        sa = a_ack; sb = b_ack; lat = i;
        break;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; psram_ready = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge mem_clk);
    n_vec++;
    if ({psram_quad_start, psram_read_write, a_ack, b_ack, busy, err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {psram_quad_start, psram_read_write, a_ack, b_ack, busy, err});
    end
    n_vec++;
    if (psram_address !== 23'h0 || psram_data_in !== 16'h0) begin
      n_err++;
      $display("FAIL reset_bus: addr %h data %h expected 0", psram_address, psram_data_in);
    end
    n_vec++;
    if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_rdata: a %h b %h expected 0", a_rdata, b_rdata);
    end
    n_vec++;
    if (dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_init_gating();
    bit seen, sa, sb; int lat, q0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000010;
    model_delay = 14; model_data = 16'h1234;
    @(negedge mem_clk);
    rst_n = 1'b1;
    q0 = n_qs;
    repeat (50) @(negedge mem_clk);
    n_vec++;
    if (n_qs != q0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL init_gate: starts %0d busy %b expected 0 starts busy 1", n_qs - q0, busy);
    end
    psram_ready = 1'b1;
    wait_qs(3, seen);
    n_vec++;
    if (!seen || psram_read_write !== 2'd2 || psram_address !== 23'h000010) begin
      n_err++;
      $display("FAIL init_start: seen %b rw %0d addr %h expected 1 2 000010", seen, psram_read_write, psram_address);
    end
    wait_ack(300, sa, sb, lat);
    a_req = 1'b0;
    n_vec++;
    if (!sa || sb || lat != 15 || a_rdata !== 16'h1234) begin
      n_err++;
      $display("FAIL init_read: a %b b %b lat %0d rdata %h expected 1 0 15 1234", sa, sb, lat, a_rdata);
    end
  endtask

  task automatic test_write_read();
    bit seen, sa, sb; int lat;
    a_req = 1'b1; a_we = 1'b1; a_addr = 23'h000123; a_wdata = 16'hBEEF; model_data = 16'h0BAD;
    wait_qs(20, seen);
    n_vec++;
    if (!seen || psram_read_write !== 2'd1 || psram_address !== 23'h000123 || psram_data_in !== 16'hBEEF) begin
      n_err++;
      $display("FAIL wr_start: seen %b rw %0d addr %h data %h expected 1 1 000123 beef",
               seen, psram_read_write, psram_address, psram_data_in);
    end
    @(negedge mem_clk);
    n_vec++;
    if (psram_quad_start !== 1'b0 || busy !== 1'b1 || psram_read_write !== 2'd1) begin
      n_err++;
      $display("FAIL wr_busy: qs %b busy %b rw %0d expected 0 1 1", psram_quad_start, busy, psram_read_write);
    end
    wait_ack(300, sa, sb, lat);
    a_req = 1'b0;
    n_vec++;
    if (!sa || sb || lat != 14 || a_rdata !== 16'h1234) begin
      n_err++;
      $display("FAIL wr_ack: a %b b %b lat %0d rdata %h expected 1 0 14 1234", sa, sb, lat, a_rdata);
    end
    @(negedge mem_clk);
    n_vec++;
    if (a_ack !== 1'b0 || psram_read_write !== 2'd0) begin
      n_err++;
      $display("FAIL wr_gap: ack %b rw %0d expected 0 0", a_ack, psram_read_write);
    end
    a_req = 1'b1; a_we = 1'b0; model_data = 16'hBEEF;
    wait_qs(20, seen);
    n_vec++;
    if (!seen || psram_read_write !== 2'd2 || psram_address !== 23'h000123) begin
      n_err++;
      $display("FAIL rd_start: seen %b rw %0d addr %h expected 1 2 000123", seen, psram_read_write, psram_address);
    end
    wait_ack(300, sa, sb, lat);
    a_req = 1'b0;
    n_vec++;
    if (!sa || sb || lat != 15 || a_rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL rd_ack: a %b b %b lat %0d rdata %h expected 1 0 15 beef", sa, sb, lat, a_rdata);
    end
  endtask

  task automatic test_port_b();
    bit seen, sa, sb; int lat;
    b_req = 1'b1; b_we = 1'b0; b_addr = 23'h7FFFFF; model_data = 16'hC0DE;
    wait_qs(20, seen);
    n_vec++;
    if (!seen || psram_read_write !== 2'd2 || psram_address !== 23'h7FFFFF) begin
      n_err++;
      $display("FAIL b_start: seen %b rw %0d addr %h expected 1 2 7fffff", seen, psram_read_write, psram_address);
    end
    wait_ack(300, sa, sb, lat);
    b_req = 1'b0;
    n_vec++;
    if (sa || !sb || lat != 15 || b_rdata !== 16'hC0DE || a_rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL b_ack: a %b b %b lat %0d brd %h ard %h expected 0 1 15 c0de beef",
               sa, sb, lat, b_rdata, a_rdata);
    end
  endtask

  task automatic test_round_robin();
    bit seen, sa, sb; int lat, prev_cyc; logic [0:0] exp_port; logic [15:0] got, want;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000200;
    b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000300;
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      want = 16'hA000 + 16'(i);
      model_data = want;
      exp_port = exp_q.pop_front();
      wait_qs(30, seen);
      n_vec++;
      if (!seen || psram_address !== (exp_port[0] ? 23'h000300 : 23'h000200)) begin
        n_err++;
        $display("FAIL rr_grant%0d: seen %b addr %h expected port %0d", i, seen, psram_address, exp_port);
      end
      if (i > 0) begin
        n_vec++;
        if (cyc - prev_cyc != 20) begin
          n_err++;
          $display("FAIL rr_spacing%0d: got %0d expected 20", i, cyc - prev_cyc);
        end
      end
      prev_cyc = cyc;
      wait_ack(300, sa, sb, lat);
      if (i == 3) begin a_req = 1'b0; b_req = 1'b0; end
      got = exp_port[0] ? b_rdata : a_rdata;
      n_vec++;
      if (sa !== ~exp_port[0] || sb !== exp_port[0] || lat != 15 || got !== want) begin
        n_err++;
        $display("FAIL rr_ack%0d: a %b b %b lat %0d rdata %h expected port %0d lat 15 rdata %h",
                 i, sa, sb, lat, got, exp_port, want);
      end
    end
  endtask

  task automatic test_timeout();
    bit seen, sa, sb; int lat;
    model_delay = 0; a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000400;
    wait_qs(20, seen);
    n_vec++;
    if (!seen || err !== 1'b0) begin
      n_err++;
      $display("FAIL to_start: seen %b err %b expected 1 0", seen, err);
    end
    wait_ack(400, sa, sb, lat);
    a_req = 1'b0;
    n_vec++;
    if (!sa || sb || lat != 256 || err !== 1'b1 || a_rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL to_abort: a %b b %b lat %0d err %b rdata %h expected 1 0 256 1 0000",
               sa, sb, lat, err, a_rdata);
    end
    model_delay = 14; model_data = 16'h5A5A; a_req = 1'b1; a_addr = 23'h000401;
    wait_qs(20, seen);
    wait_ack(300, sa, sb, lat);
    a_req = 1'b0;
    n_vec++;
    if (!seen || !sa || lat != 15 || a_rdata !== 16'h5A5A || err !== 1'b1) begin
      n_err++;
      $display("FAIL to_recover: seen %b a %b lat %0d rdata %h err %b expected 1 1 15 5a5a 1",
               seen, sa, lat, a_rdata, err);
    end
  endtask

  task automatic test_early_end();
    bit seen, sa, sb; int lat;
    model_stuck = 1'b1; model_data = 16'h7777;
    repeat (2) @(negedge mem_clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000500;
    wait_qs(20, seen);
    wait_ack(20, sa, sb, lat);
    a_req = 1'b0; model_stuck = 1'b0;
    n_vec++;
    if (!seen || !sa || sb || lat != 3 || a_rdata !== 16'h7777) begin
      n_err++;
      $display("FAIL early_end: seen %b a %b b %b lat %0d rdata %h expected 1 1 0 3 7777",
               seen, sa, sb, lat, a_rdata);
    end
  endtask

  task automatic test_ready_drop();
    bit seen, sa, sb; int lat, ack0, qs0;
    model_delay = 0; a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000600;
    wait_qs(20, seen);
    repeat (5) @(negedge mem_clk);
    n_vec++;
    if (!seen || dbg_state !== 3'd3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL drop_busy: seen %b state %0d busy %b expected 1 3 1", seen, dbg_state, busy);
    end
    ack0 = n_a_ack + n_b_ack; qs0 = n_qs;
    psram_ready = 1'b0;
    @(negedge mem_clk);
    n_vec++;
    if (dbg_state !== 3'd0 || psram_read_write !== 2'd0 || psram_quad_start !== 1'b0 || err !== 1'b1) begin
      n_err++;
      $display("FAIL drop_state: state %0d rw %0d qs %b err %b expected 0 0 0 1",
               dbg_state, psram_read_write, psram_quad_start, err);
    end
    repeat (20) @(negedge mem_clk);
    n_vec++;
    if (n_a_ack + n_b_ack != ack0 || n_qs != qs0) begin
      n_err++;
      $display("FAIL drop_quiet: acks %0d starts %0d expected 0 0", n_a_ack + n_b_ack - ack0, n_qs - qs0);
    end
    model_delay = 14; model_data = 16'h6666; psram_ready = 1'b1;
    wait_qs(3, seen);
    wait_ack(300, sa, sb, lat);
    a_req = 1'b0;
    n_vec++;
    if (!seen || !sa || lat != 15 || a_rdata !== 16'h6666) begin
      n_err++;
      $display("FAIL drop_recover: seen %b a %b lat %0d rdata %h expected 1 1 15 6666", seen, sa, lat, a_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int qs0;
    model_delay = 0; a_req = 1'b1; a_we = 1'b1; a_addr = 23'h000700; a_wdata = 16'h1111;
    wait_qs(20, seen);
    repeat (5) @(negedge mem_clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (!seen || {psram_quad_start, psram_read_write, a_ack, b_ack, busy, err} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_mid_ctrl: seen %b got %b expected 0000000",
               seen, {psram_quad_start, psram_read_write, a_ack, b_ack, busy, err});
    end
    n_vec++;
    if (psram_address !== 23'h0 || psram_data_in !== 16'h0 || a_rdata !== 16'h0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid_data: addr %h din %h ard %h state %0d expected 0 0 0 0",
               psram_address, psram_data_in, a_rdata, dbg_state);
    end
    a_req = 1'b0;
    @(negedge mem_clk);
    rst_n = 1'b1;
    qs0 = n_qs;
    repeat (10) @(negedge mem_clk);
    n_vec++;
    if (n_qs != qs0 || dbg_state !== 3'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_idle: starts %0d state %0d busy %b expected 0 1 0", n_qs - qs0, dbg_state, busy);
    end
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_write_read();
    test_port_b();
    test_round_robin();
    test_timeout();
    test_early_end();
    test_ready_drop();
    test_reset_mid();
    n_vec++;
    if (n_both != 0) begin
      n_err++;
      $display("FAIL ack_exclusive: got %0d dual-ack cycles expected 0", n_both);
    end
    n_vec++;
    if (n_a_ack + n_b_ack != 12 || n_qs != 14) begin
      n_err++;
      $display("FAIL totals: acks %0d starts %0d expected 12 14", n_a_ack + n_b_ack, n_qs);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
